// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end: fetch FSM states,
// datapath widths and the opcode map consumed by the decoder ROM.
package cpu_pkg;

    // Instruction word, opcode field and memory data widths
    localparam int INSTR_W    = 16;
    localparam int OPC_W      = 4;
    localparam int MEM_DATA_W = 8;

    // Fetch sequencing: high byte, low byte, then hold for decode
    typedef enum logic [1:0] {
        FETCH_HI = 2'd0,
        FETCH_LO = 2'd1,
        HOLD     = 2'd2
    } fetch_state_t;

    // Opcode map, indexed by instr[15:12]
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h2;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h3;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'h4;
    localparam logic [OPC_W-1:0] OP_NOT  = 4'h5;
    localparam logic [OPC_W-1:0] OP_SHL  = 4'h6;
    localparam logic [OPC_W-1:0] OP_SHR  = 4'h7;
    localparam logic [OPC_W-1:0] OP_LD   = 4'h8;
    localparam logic [OPC_W-1:0] OP_ST   = 4'h9;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'hA;
    localparam logic [OPC_W-1:0] OP_BEQ  = 4'hB;
    localparam logic [OPC_W-1:0] OP_BNE  = 4'hC;
    localparam logic [OPC_W-1:0] OP_CALL = 4'hD;
    localparam logic [OPC_W-1:0] OP_RET  = 4'hE;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'hF;

    // Opcode lives in the top nibble of the instruction word
    function automatic logic [OPC_W-1:0] getOpcode(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads 16-bit big-endian instructions as two
// byte reads from instruction memory and hands them to decode over a
// valid/ready handshake. A redirect from execute flushes any fetch in
// progress and restarts fetching at the new target.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_mem_req,
    output logic [PC_W-1:0]       o_mem_addr,
    input  logic                  i_mem_ack,
    input  logic [MEM_DATA_W-1:0] i_mem_rdata,
    output logic [INSTR_W-1:0]    o_instr,
    output logic [OPC_W-1:0]      o_opcode,
    output logic [PC_W-1:0]       o_instr_pc,
    output logic                  o_instr_valid,
    input  logic                  i_instr_ready,
    input  logic                  i_redirect,
    input  logic [PC_W-1:0]       i_redirect_pc
);

    fetch_state_t          r_state;
    logic [PC_W-1:0]       r_pc;
    logic [MEM_DATA_W-1:0] r_hiByte;
    logic [INSTR_W-1:0]    r_instr;
    logic [PC_W-1:0]       r_instrPc;
    logic                  r_instrValid;
    logic                  r_memReq;

    logic                  w_memAck;
    logic                  w_accept;
    logic [PC_W-1:0]       w_pcPlus1;
    logic [PC_W-1:0]       w_pcPlus2;
    logic [PC_W-1:0]       w_memAddr;

    // An ack only means something while a request is actually out
    assign w_memAck  = i_mem_ack & r_memReq;
    assign w_accept  = r_instrValid & i_instr_ready;
    assign w_pcPlus1 = r_pc + PC_W'(1);
    assign w_pcPlus2 = r_pc + PC_W'(2);

    // Byte address follows the FSM: high byte at pc, low byte at pc+1 (wrapping)
    always_comb begin
        w_memAddr = r_pc;
        if (r_state == FETCH_LO) begin
            w_memAddr = w_pcPlus1;
        end
    end

    // Fetch FSM, pc and instruction register; reset beats redirect beats everything else
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= FETCH_HI;
            r_pc         <= RESET_PC;
            r_hiByte     <= '0;
            r_instr      <= '0;
            r_instrPc    <= '0;
            r_instrValid <= 1'b0;
            r_memReq     <= 1'b0;
        end else if (i_redirect) begin
            r_state      <= FETCH_HI;
            r_pc         <= i_redirect_pc;
            r_instrValid <= 1'b0;
            r_memReq     <= 1'b1;
        end else begin
            case (r_state)
                FETCH_HI: begin
                    r_memReq <= 1'b1;
                    if (w_memAck) begin
                        r_hiByte <= i_mem_rdata;
                        r_state  <= FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    r_memReq <= 1'b1;
                    if (w_memAck) begin
                        r_instr      <= {r_hiByte, i_mem_rdata};
                        r_instrPc    <= r_pc;
                        r_instrValid <= 1'b1;
                        r_memReq     <= 1'b0;
                        r_state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_accept) begin
                        r_instrValid <= 1'b0;
                        r_pc         <= w_pcPlus2;
                        r_memReq     <= 1'b1;
                        r_state      <= FETCH_HI;
                    end else begin
                        r_memReq <= 1'b0;
                    end
                end
                default: begin
                    r_memReq <= 1'b0;
                    r_state  <= FETCH_HI;
                end
            endcase
        end
    end

    assign o_mem_req     = r_memReq;
    assign o_mem_addr    = w_memAddr;
    assign o_instr       = r_instr;
    assign o_opcode      = getOpcode(r_instr);
    assign o_instr_pc    = r_instrPc;
    assign o_instr_valid = r_instrValid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a byte-wide memory responder and a
// scoreboard of expected instructions checked on every decode handoff.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            memReq;
    logic [PC_W-1:0] memAddr;
    logic            memAck;
    logic [7:0]      memRdata;
    logic [15:0]     instr;
    logic [3:0]      opcode;
    logic [PC_W-1:0] instrPc;
    logic            instrValid;
    logic            instrReady;
    logic            redirect;
    logic [PC_W-1:0] redirectPc;

    fetch_unit #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_mem_req    (memReq),
        .o_mem_addr   (memAddr),
        .i_mem_ack    (memAck),
        .i_mem_rdata  (memRdata),
        .o_instr      (instr),
        .o_opcode     (opcode),
        .o_instr_pc   (instrPc),
        .o_instr_valid(instrValid),
        .i_instr_ready(instrReady),
        .i_redirect   (redirect),
        .i_redirect_pc(redirectPc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]     instr;
        logic [PC_W-1:0] pc;
    } exp_t;

    logic [7:0] mem [256];
    exp_t       sbQueue [$];
    int         waitStates = 0;
    int         waitCnt    = 0;
    int         assertCount = 0;
    int         failCount   = 0;

    // One comparison: counts it and reports tag/observed/expected on failure
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t expectAt(input logic [PC_W-1:0] pc);
        logic [PC_W-1:0] pcLo;
        exp_t e;
        pcLo    = pc + 8'd1;
        e.instr = {mem[pc], mem[pcLo]};
        e.pc    = pc;
        return e;
    endfunction

    // Advance one cycle; inputs are driven 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic ready, input logic redir, input logic [PC_W-1:0] target);
        instrReady = ready;
        redirect   = redir;
        redirectPc = target;
    endtask

    task automatic waitValid(input int maxCycles, input string tag);
        int n = 0;
        while (!instrValid && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput(tag, {31'd0, instrValid}, 32'd1);
    endtask

    // Memory responder: acks after waitStates idle cycles with the addressed byte
    always @(posedge clk) begin
        #1;
        if (rst || !memReq) begin
            memAck   = 1'b0;
            memRdata = 8'hEE;
            waitCnt  = 0;
        end else if (waitCnt >= waitStates) begin
            memAck   = 1'b1;
            memRdata = mem[memAddr];
            waitCnt  = 0;
        end else begin
            memAck   = 1'b0;
            memRdata = 8'hEE;
            waitCnt++;
        end
    end

    // Scoreboard: every handoff to decode pops one expected instruction
    always @(negedge clk) begin
        exp_t e;
        if (!rst && instrValid && instrReady) begin
            if (sbQueue.size() == 0) begin
                checkOutput("sbUnexpected", {16'd0, instr}, 32'hDEAD);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("sbInstr", {16'd0, instr}, {16'd0, e.instr});
                checkOutput("sbOpcode", {28'd0, opcode}, {28'd0, e.instr[15:12]});
                checkOutput("sbInstrPc", {24'd0, instrPc}, {24'd0, e.pc});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        mem[8'h00] = 8'hC3; mem[8'h01] = 8'h05;
        mem[8'h02] = 8'h2A; mem[8'h03] = 8'h7E;
        mem[8'h04] = 8'h61; mem[8'h05] = 8'hB4;
        mem[8'h40] = 8'h5B; mem[8'h41] = 8'h19;
        mem[8'hFF] = 8'h9A;
        memAck = 1'b0; memRdata = 8'hEE;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Reset held three cycles
        repeat (3) tick();
        checkOutput("rstMemReq", {31'd0, memReq}, 32'd0);
        checkOutput("rstValid", {31'd0, instrValid}, 32'd0);
        checkOutput("rstInstr", {16'd0, instr}, 32'd0);
        checkOutput("rstInstrPc", {24'd0, instrPc}, 32'd0);
        rst = 1'b0;
        sbQueue.push_back(expectAt(8'h00));
        tick();
        checkOutput("firstReq", {31'd0, memReq}, 32'd1);
        checkOutput("firstAddr", {24'd0, memAddr}, 32'h00);

        // Basic zero-wait fetch: valid two cycles after the first request
        tick();
        checkOutput("basicLoAddr", {24'd0, memAddr}, 32'h01);
        checkOutput("basicNotYet", {31'd0, instrValid}, 32'd0);
        tick();
        checkOutput("basicValid", {31'd0, instrValid}, 32'd1);
        checkOutput("basicInstr", {16'd0, instr}, 32'hC305);
        checkOutput("basicOpcode", {28'd0, opcode}, 32'hC);
        checkOutput("basicHoldReq", {31'd0, memReq}, 32'd0);
        waitStates = 3;
        sbQueue.push_back(expectAt(8'h02));
        applyStimulus(1'b1, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Wait states: address must stay put until the ack
        for (int i = 0; i < 3; i++) begin
            checkOutput("waitHiAddr", {24'd0, memAddr}, 32'h02);
            checkOutput("waitHiReq", {31'd0, memReq}, 32'd1);
            tick();
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput("waitLoAddr", {24'd0, memAddr}, 32'h03);
            tick();
        end
        waitValid(10, "waitValidTimeout");

        // Backpressure: instruction frozen, no requests while not ready
        for (int i = 0; i < 4; i++) begin
            checkOutput("bpValid", {31'd0, instrValid}, 32'd1);
            checkOutput("bpInstr", {16'd0, instr}, 32'h2A7E);
            checkOutput("bpInstrPc", {24'd0, instrPc}, 32'h02);
            checkOutput("bpNoReq", {31'd0, memReq}, 32'd0);
            tick();
        end
        waitStates = 0;
        applyStimulus(1'b1, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("bpNextAddr", {24'd0, memAddr}, 32'h04);

        // Redirect in FETCH_LO with a simultaneous ack: that data is dropped
        tick();
        checkOutput("rdLoAddr", {24'd0, memAddr}, 32'h05);
        sbQueue.push_back(expectAt(8'h40));
        applyStimulus(1'b0, 1'b1, 8'h40);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("rdNewAddr", {24'd0, memAddr}, 32'h40);
        checkOutput("rdNoValid", {31'd0, instrValid}, 32'd0);
        waitValid(10, "rdValidTimeout");
        checkOutput("rdInstrPc", {24'd0, instrPc}, 32'h40);

        // Redirect with a handoff in the same cycle, to the wrapping address
        mem[8'h00] = 8'h12;
        sbQueue.push_back(expectAt(8'hFF));
        applyStimulus(1'b1, 1'b1, 8'hFF);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("wrapHiAddr", {24'd0, memAddr}, 32'hFF);
        checkOutput("wrapNoValid", {31'd0, instrValid}, 32'd0);
        tick();
        checkOutput("wrapLoAddr", {24'd0, memAddr}, 32'h00);
        tick();
        checkOutput("wrapInstr", {16'd0, instr}, 32'h9A12);
        checkOutput("wrapInstrPc", {24'd0, instrPc}, 32'hFF);
        applyStimulus(1'b1, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("wrapNextAddr", {24'd0, memAddr}, 32'h01);

        // Reset while holding a valid instruction
        waitValid(10, "r6ValidTimeout");
        rst = 1'b1;
        tick();
        checkOutput("r6Valid", {31'd0, instrValid}, 32'd0);
        checkOutput("r6MemReq", {31'd0, memReq}, 32'd0);
        checkOutput("r6Instr", {16'd0, instr}, 32'd0);
        rst = 1'b0;
        sbQueue.push_back(expectAt(8'h00));
        tick();
        checkOutput("r6Req", {31'd0, memReq}, 32'd1);
        checkOutput("r6Addr", {24'd0, memAddr}, 32'h00);
        waitValid(10, "r6RefetchTimeout");
        applyStimulus(1'b1, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("sbDrained", 32'(sbQueue.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
